// File: rtl/decode_stage.sv
// RV32I decode stage: one instruction per cycle from fetch into a single output register toward execute.
// Optional RAW scoreboard/stall logic is compiled in with `define DECODE_SCOREBOARD_EN.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            i_CLK,
  input  logic            i_RSTn,
  input  logic            i_INSTR_VALID,
  output logic            o_INSTR_READY,
  input  logic [31:0]     i_INSTR,
  input  logic [XLEN-1:0] i_PC,
  output logic [4:0]      o_RS1_PTR,
  output logic [4:0]      o_RS2_PTR,
  input  logic [XLEN-1:0] i_RS1,
  input  logic [XLEN-1:0] i_RS2,
  input  logic            i_WB_WE,
  input  logic [4:0]      i_WB_RD_PTR,
  input  logic            i_FLUSH,
  output logic            o_EX_VALID,
  input  logic            i_EX_READY,
  output logic [XLEN-1:0] o_EX_PC,
  output logic [XLEN-1:0] o_EX_RS1,
  output logic [XLEN-1:0] o_EX_RS2,
  output logic [31:0]     o_EX_IMM,
  output logic [4:0]      o_EX_RD_PTR,
  output logic            o_EX_RD_WE,
  output logic [3:0]      o_EX_OPCLASS,
  output logic [2:0]      o_EX_FUNCT3,
  output logic            o_EX_FUNCT7B5,
  output logic            o_EX_ILLEGAL
);
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Handshake: a transfer happens on a cycle where valid and ready are both 1;
  // valid never waits on ready, and the output register holds stable while valid & !ready.
  logic accept, drain, hazard;

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] imm;
  logic [3:0]  opclass;
  logic        writes_rd, use_rs1, use_rs2;
  logic [4:0]  rd;

  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_d, ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic [31:0]     ex_imm_q, ex_imm_d;
  logic [4:0]      ex_rd_q, ex_rd_d;
  logic            ex_rd_we_q, ex_rd_we_d;
  logic [3:0]      ex_opclass_q, ex_opclass_d;
  logic [2:0]      ex_funct3_q, ex_funct3_d;
  logic            ex_funct7b5_q, ex_funct7b5_d;
  logic            ex_illegal_q, ex_illegal_d;

  assign o_RS1_PTR = i_INSTR[19:15];
  assign o_RS2_PTR = i_INSTR[24:20];
  assign rd        = i_INSTR[11:7];

  assign imm_i = {{20{i_INSTR[31]}}, i_INSTR[31:20]};
  assign imm_s = {{20{i_INSTR[31]}}, i_INSTR[31:25], i_INSTR[11:7]};
  assign imm_b = {{19{i_INSTR[31]}}, i_INSTR[31], i_INSTR[7], i_INSTR[30:25], i_INSTR[11:8], 1'b0};
  assign imm_u = {i_INSTR[31:12], 12'h000};
  assign imm_j = {{11{i_INSTR[31]}}, i_INSTR[31], i_INSTR[19:12], i_INSTR[20], i_INSTR[30:21], 1'b0};

  always_comb begin
    opclass   = 4'd15;
    imm       = '0;
    writes_rd = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    case (i_INSTR[6:0])
      OPC_LUI:      begin opclass = 4'd0;  imm = imm_u; writes_rd = 1'b1; end
      OPC_AUIPC:    begin opclass = 4'd1;  imm = imm_u; writes_rd = 1'b1; end
      OPC_JAL:      begin opclass = 4'd2;  imm = imm_j; writes_rd = 1'b1; end
      OPC_JALR:     begin opclass = 4'd3;  imm = imm_i; writes_rd = 1'b1; use_rs1 = 1'b1; end
      OPC_BRANCH:   begin opclass = 4'd4;  imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_LOAD:     begin opclass = 4'd5;  imm = imm_i; writes_rd = 1'b1; use_rs1 = 1'b1; end
      OPC_STORE:    begin opclass = 4'd6;  imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_OP_IMM:   begin opclass = 4'd7;  imm = imm_i; writes_rd = 1'b1; use_rs1 = 1'b1; end
      OPC_OP:       begin opclass = 4'd8;  writes_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_MISC_MEM: begin opclass = 4'd9;  imm = imm_i; end
      OPC_SYSTEM:   begin opclass = 4'd10; imm = imm_i; end
      default:      ;
    endcase
  end

  // Ready is forced low while reset is asserted so fetch never sees a phantom accept.
  assign o_INSTR_READY = i_RSTn & (~ex_valid_q | i_EX_READY) & ~hazard & ~i_FLUSH;
  assign accept        = i_INSTR_VALID & o_INSTR_READY;
  assign drain         = ex_valid_q & i_EX_READY;

`ifdef DECODE_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;
  logic        haz_rs1, haz_rs2;

  // A same-cycle writeback to a busy source bypasses through the regfile; the output register never does.
  always_comb begin
    haz_rs1 = use_rs1 && (o_RS1_PTR != 5'd0) &&
              ((busy_q[o_RS1_PTR] && !(i_WB_WE && (i_WB_RD_PTR == o_RS1_PTR))) ||
               (ex_valid_q && ex_rd_we_q && (ex_rd_q == o_RS1_PTR)));
    haz_rs2 = use_rs2 && (o_RS2_PTR != 5'd0) &&
              ((busy_q[o_RS2_PTR] && !(i_WB_WE && (i_WB_RD_PTR == o_RS2_PTR))) ||
               (ex_valid_q && ex_rd_we_q && (ex_rd_q == o_RS2_PTR)));
    hazard  = haz_rs1 | haz_rs2;
  end

  always_comb begin
    busy_d = busy_q;
    if (i_WB_WE && (i_WB_RD_PTR != 5'd0)) busy_d[i_WB_RD_PTR] = 1'b0;
    if (drain && ex_rd_we_q && !i_FLUSH)   busy_d[ex_rd_q]     = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) busy_q <= '0;
    else         busy_q <= busy_d;
  end
`else
  logic unused_sb;
  assign hazard    = 1'b0;
  assign unused_sb = ^{i_WB_WE, i_WB_RD_PTR, use_rs1, use_rs2};
`endif

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_imm_d      = ex_imm_q;
    ex_rd_d       = ex_rd_q;
    ex_rd_we_d    = ex_rd_we_q;
    ex_opclass_d  = ex_opclass_q;
    ex_funct3_d   = ex_funct3_q;
    ex_funct7b5_d = ex_funct7b5_q;
    ex_illegal_d  = ex_illegal_q;
    if (accept) begin
      ex_valid_d    = 1'b1;
      ex_pc_d       = i_PC;
      ex_rs1_d      = i_RS1;
      ex_rs2_d      = i_RS2;
      ex_imm_d      = imm;
      ex_rd_d       = rd;
      ex_rd_we_d    = writes_rd && (rd != 5'd0);
      ex_opclass_d  = opclass;
      ex_funct3_d   = i_INSTR[14:12];
      ex_funct7b5_d = i_INSTR[30];
      ex_illegal_d  = (opclass == 4'd15);
    end else if (drain || i_FLUSH) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_imm_q      <= '0;
      ex_rd_q       <= '0;
      ex_rd_we_q    <= 1'b0;
      ex_opclass_q  <= '0;
      ex_funct3_q   <= '0;
      ex_funct7b5_q <= 1'b0;
      ex_illegal_q  <= 1'b0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_imm_q      <= ex_imm_d;
      ex_rd_q       <= ex_rd_d;
      ex_rd_we_q    <= ex_rd_we_d;
      ex_opclass_q  <= ex_opclass_d;
      ex_funct3_q   <= ex_funct3_d;
      ex_funct7b5_q <= ex_funct7b5_d;
      ex_illegal_q  <= ex_illegal_d;
    end
  end

  assign o_EX_VALID    = ex_valid_q;
  assign o_EX_PC       = ex_pc_q;
  assign o_EX_RS1      = ex_rs1_q;
  assign o_EX_RS2      = ex_rs2_q;
  assign o_EX_IMM      = ex_imm_q;
  assign o_EX_RD_PTR   = ex_rd_q;
  assign o_EX_RD_WE    = ex_rd_we_q;
  assign o_EX_OPCLASS  = ex_opclass_q;
  assign o_EX_FUNCT3   = ex_funct3_q;
  assign o_EX_FUNCT7B5 = ex_funct7b5_q;
  assign o_EX_ILLEGAL  = ex_illegal_q;
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I decode stage between fetch and execute.
- Accepts one instruction per cycle over a valid/ready handshake and drives the regfile read pointers.
- Captures the regfile read data (`o_RS1`/`o_RS2` of the regfile, which forwards same-cycle writeback) together with the decoded fields into one output pipeline register toward execute.
- A 31-entry pending-write scoreboard stalls read-after-write hazards until writeback.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- i_CLK  in  1  clock, all state on rising edge
- i_RSTn  in  1  asynchronous active-low reset
- i_INSTR_VALID  in  1  fetch has an instruction
- o_INSTR_READY  out  1  decode accepts this cycle
- i_INSTR  in  32  instruction word
- i_PC  in  32  instruction address
- o_RS1_PTR  out  5  regfile read pointer 1, = i_INSTR[19:15], combinational
- o_RS2_PTR  out  5  regfile read pointer 2, = i_INSTR[24:20], combinational
- i_RS1  in  32  regfile read data 1
- i_RS2  in  32  regfile read data 2
- i_WB_WE  in  1  writeback write enable, same signal the regfile sees
- i_WB_RD_PTR  in  5  writeback destination
- i_FLUSH  in  1  kill the output register and drop the incoming instruction
- o_EX_VALID  out  1  output register holds an instruction
- i_EX_READY  in  1  execute consumes this cycle
- o_EX_PC  out  32  registered PC
- o_EX_RS1  out  32  registered operand 1
- o_EX_RS2  out  32  registered operand 2
- o_EX_IMM  out  32  sign-extended immediate
- o_EX_RD_PTR  out  5  destination register
- o_EX_RD_WE  out  1  instruction writes a nonzero rd
- o_EX_OPCLASS  out  4  opcode class
- o_EX_FUNCT3  out  3  instr[14:12]
- o_EX_FUNCT7B5  out  1  instr[30]
- o_EX_ILLEGAL  out  1  undecodable opcode

Behaviour:
- **Reset.** While i_RSTn=0, all o_EX_* registers are 0, the scoreboard is all 0, and o_INSTR_READY=0.
- **Handshakes.**
  - Accept = i_INSTR_VALID & o_INSTR_READY.
  - Drain = o_EX_VALID & i_EX_READY.
  - o_INSTR_READY = (!o_EX_VALID | i_EX_READY) & !hazard & !i_FLUSH.
  - Latency: accept in cycle N gives o_EX_VALID in N+1; the pipeline sustains 1 instruction per cycle with no hazards.
- **Output register update.**
  - On accept: load all o_EX_* fields and set o_EX_VALID=1.
  - Else on drain: clear o_EX_VALID.
  - Otherwise hold; data is stable while o_EX_VALID=1 and i_EX_READY=0.
- **Opcode classes** (instr[6:0]):
  - LUI=0, AUIPC=1, JAL=2, JALR=3, BRANCH=4, LOAD=5, STORE=6, OP_IMM=7, OP=8, MISC_MEM=9, SYSTEM=10.
  - Anything else, including instr[1:0]!=2'b11, is class 15, o_EX_ILLEGAL=1, IMM=0, RD_WE=0.
- **Immediates.** I (JALR, LOAD, OP_IMM, SYSTEM), S (STORE), B (BRANCH, bit0=0), U (LUI, AUIPC, low 12 bits zero), J (JAL, bit0=0). MISC_MEM uses I.
- **o_EX_RD_WE.** 1 for LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP when rd!=0; otherwise 0.
- **Register use.**
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OP_IMM, OP.
  - rs2 is used by BRANCH, STORE, OP.
  - x0 never hazards.
- **Scoreboard** (bits 1..31):
  - Set bit[o_EX_RD_PTR] on drain & o_EX_RD_WE & !i_FLUSH.
  - Clear bit[i_WB_RD_PTR] on i_WB_WE with i_WB_RD_PTR!=0.
  - Set and clear of the same bit in the same cycle: set wins.
- **Hazard.** For each used rs, hazard = (busy[rs] & !(i_WB_WE & i_WB_RD_PTR==rs)) | (o_EX_VALID & o_EX_RD_WE & o_EX_RD_PTR==rs).
  - A writeback in the same cycle bypasses, because the regfile forwards it.
  - A matching instruction still in the output register always stalls.
- **Flush.**
  - Next cycle o_EX_VALID=0.
  - A drain in the same cycle is void: no scoreboard set.
  - The incoming instruction is not accepted.
  - Existing busy bits are kept, since older instructions still write back.
- **Reset mid-operation.** Asynchronous return to reset values; in-flight state is discarded.

Optional Feature:
- Macro: DECODE_SCOREBOARD_EN.
- Defined: scoreboard and hazard logic as above.
- Undefined:
  - No scoreboard flops and hazard=0.
  - i_WB_WE and i_WB_RD_PTR are ignored.
  - Execute-stage forwarding resolves dependencies.
  - All other behaviour is identical.

Test Plan:
1. **Reset.** Hold i_RSTn=0 with i_INSTR_VALID=1 → o_INSTR_READY=0, o_EX_VALID=0, all o_EX_*=0.
2. **ADDI decode.** ADDI x5,x1,-3 (0xFFD08293) with i_RS1=10 → next cycle OPCLASS=7, IMM=0xFFFFFFFD, RD_PTR=5, RD_WE=1, EX_RS1=10.
3. **Back-pressure.** i_EX_READY=0 for 3 cycles with the next instruction valid → o_INSTR_READY=0 and o_EX_* held unchanged; on release, both instructions pass in order.
4. **RAW hazard** (DECODE_SCOREBOARD_EN). Issue ADD x3,x1,x2, then SUB x4,x3,x1.
   - SUB stalls until i_WB_WE=1, i_WB_RD_PTR=3.
   - SUB is accepted in that same cycle with i_RS1 = the writeback value.
5. **Flush.** i_FLUSH together with drain of LW x6 → o_EX_VALID=0 next cycle, busy[6] stays 0, and a following use of x6 does not stall.
6. **Illegal and x0.** Instruction 0x00000000 → OPCLASS=15, ILLEGAL=1, RD_WE=0. ADDI x0,x0,1 → RD_WE=0 and no scoreboard bit set.
